quant_pack_stream: RTL and testbench

Output stage directly downstream of the systolic array that img2col_stream and weight_cache feed. Consumes LANES parallel 32-bit accumulator results per beat. Applies per-output-channel bias, scale and a global right shift with rounding and int8 saturation. Packs the LANES bytes into one 64-bit beat with a last flag, for the DMA/write-back path.

---
 rtl/quant_pkg.sv | 27 ++
 rtl/quant_lane.sv | 39 +++
 rtl/quant_pack_stream.sv | 167 ++++++++++++++++
 tb/tb_quant_pack_stream.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_pkg.sv
// Shared widths, parameter-word layout, FSM states and int8 saturation for the
// quantise-and-pack output stage.
package quant_pkg;

   localparam int unsigned LANES     = 8;
   localparam int unsigned ACC_W     = 32;
   localparam int unsigned SCALE_W   = 16;
   localparam int unsigned BIAS_W    = 32;
   localparam int unsigned CH_MAX    = 1024;
   localparam int unsigned P_W       = BIAS_W + SCALE_W;
   localparam int unsigned BIAS_LSB  = 16;
   localparam int unsigned SCALE_LSB = 0;
   localparam int unsigned SUM_W     = ACC_W + 1;
   localparam int unsigned PROD_W    = SUM_W + SCALE_W + 1;
   localparam int unsigned OUT_W     = LANES * 8;
   localparam int unsigned SHIFT_W   = 5;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   // Clamp a scaled/shifted product into the int8 range.
   function automatic logic [7:0] sat_int8(input logic signed [PROD_W-1:0] v);
      if (v > PROD_W'(127)) return 8'h7f;
      else if (v < PROD_W'(-128)) return 8'h80;
      else return v[7:0];
   endfunction

endpackage

// File: rtl/quant_lane.sv
// One lane of the output arithmetic: bias add, then scale, round, shift and
// saturate into a registered int8.
module quant_lane
   import quant_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [ACC_W-1:0]   acc,
   input  logic [BIAS_W-1:0]  bias,
   input  logic [SCALE_W-1:0] scale,
   input  logic [SHIFT_W-1:0] shift,
   output logic [7:0]         q
);

   logic signed [SUM_W-1:0]  sum_q;
   logic [SCALE_W-1:0]       scale_q;
   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] rnd;
   logic signed [PROD_W-1:0] shifted;

   // Scale is unsigned, so it enters the multiply zero-extended.
   assign prod    = PROD_W'(sum_q) * PROD_W'($signed({1'b0, scale_q}));
   assign rnd     = (shift == '0) ? '0 : (PROD_W'(1) <<< (shift - SHIFT_W'(1)));
   assign shifted = (prod + rnd) >>> shift;

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         scale_q <= '0;
         q       <= '0;
      end else if (en) begin
         sum_q   <= {acc[ACC_W-1], acc} + {bias[BIAS_W-1], bias};
         scale_q <= scale;
         q       <= sat_int8(shifted);
      end
   end

endmodule

// File: rtl/quant_pack_stream.sv
// Systolic-array output stage: loads per-channel bias/scale, then turns each
// beat of LANES accumulators into one packed int8 output beat.
module quant_pack_stream
   import quant_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [15:0]            Matrix_Col,
   input  logic [19:0]            OutMatrix_Row,
   input  logic [SHIFT_W-1:0]     Shift,
   input  logic                   p_valid,
   output logic                   p_ready,
   input  logic [P_W-1:0]         p_data,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [LANES*ACC_W-1:0] s_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [OUT_W-1:0]       m_data,
   output logic                   m_last,
   output logic                   done,
   output logic                   cfg_err
);

   localparam int unsigned DEPTH  = CH_MAX / LANES;
   localparam int unsigned GRP_W  = $clog2(DEPTH);
   localparam int unsigned PCNT_W = $clog2(CH_MAX);
   localparam int unsigned LANE_W = $clog2(LANES);
   localparam int unsigned ROW_W  = 20;

   state_t               state;
   logic [PCNT_W-1:0]    pcnt;
   logic [PCNT_W-1:0]    pcnt_max;
   logic [GRP_W-1:0]     cg;
   logic [GRP_W-1:0]     cg_max;
   logic [ROW_W-1:0]     r;
   logic [ROW_W-1:0]     r_max;
   logic [SHIFT_W-1:0]   shift_q;
   logic                 fed_last;

   logic                 en;
   logic                 p_hs;
   logic                 s_hs;
   logic                 is_last;
   logic                 cfg_ok;

   logic                 v1, v2, last1, last2;
   logic [LANES*ACC_W-1:0] d1;

   assign en      = !m_valid || m_ready;
   assign p_ready = (state == LOAD);
   assign s_ready = (state == RUN) && en && !fed_last;
   assign p_hs    = p_valid && p_ready;
   assign s_hs    = s_valid && s_ready;
   assign is_last = (cg == cg_max) && (r == r_max);
   assign cfg_ok  = (Matrix_Col != '0) && (Matrix_Col[LANE_W-1:0] == '0) &&
                    (Matrix_Col <= 16'(CH_MAX)) && (OutMatrix_Row != '0);

   // Control FSM with the parameter-load and group/row counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         pcnt     <= '0;
         pcnt_max <= '0;
         cg       <= '0;
         cg_max   <= '0;
         r        <= '0;
         r_max    <= '0;
         shift_q  <= '0;
         fed_last <= 1'b0;
         done     <= 1'b0;
         cfg_err  <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pcnt_max <= PCNT_W'(Matrix_Col - 16'd1);
                  cg_max   <= GRP_W'((Matrix_Col >> LANE_W) - 16'd1);
                  r_max    <= OutMatrix_Row - ROW_W'(1);
                  shift_q  <= Shift;
                  pcnt     <= '0;
                  if (cfg_ok) state   <= LOAD;
                  else        cfg_err <= 1'b1;
               end
            end
            LOAD: begin
               if (p_hs) begin
                  pcnt <= pcnt + PCNT_W'(1);
                  if (pcnt == pcnt_max) begin
                     state    <= RUN;
                     cg       <= '0;
                     r        <= '0;
                     fed_last <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (s_hs) begin
                  if (cg == cg_max) begin
                     cg <= '0;
                     r  <= r + ROW_W'(1);
                  end else begin
                     cg <= cg + GRP_W'(1);
                  end
                  if (is_last) fed_last <= 1'b1;
               end
               if (m_valid && m_ready && m_last) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Pipeline valid/last tracking; every stage holds while the output stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1      <= 1'b0;
         last1   <= 1'b0;
         v2      <= 1'b0;
         last2   <= 1'b0;
         m_valid <= 1'b0;
         m_last  <= 1'b0;
      end else if (en) begin
         v1      <= s_hs;
         last1   <= s_hs && is_last;
         v2      <= v1;
         last2   <= last1;
         m_valid <= v2;
         m_last  <= last2;
      end
   end

   always_ff @(posedge clk) begin
      if (en) d1 <= s_data;
   end

   // Bank i holds channels i, i+LANES, ...; one read per bank fetches a group.
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [P_W-1:0] mem [DEPTH];
      logic [P_W-1:0] rd;

      always_ff @(posedge clk) begin
         if (p_hs && (pcnt[LANE_W-1:0] == LANE_W'(i)))
            mem[pcnt[PCNT_W-1:LANE_W]] <= p_data;
         if (en) rd <= mem[cg];
      end

      quant_lane u_lane (
         .clk   (clk),
         .rst   (rst),
         .en    (en),
         .acc   (d1[i*ACC_W +: ACC_W]),
         .bias  (rd[BIAS_LSB +: BIAS_W]),
         .scale (rd[SCALE_LSB +: SCALE_W]),
         .shift (shift_q),
         .q     (m_data[i*8 +: 8])
      );
   end

endmodule

// File: tb/tb_quant_pack_stream.sv
// Scoreboard bench for quant_pack_stream: expected beats are queued as
// accumulator beats are accepted and compared as output beats handshake.
module tb_quant_pack_stream;
   import quant_pkg::*;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   start;
   logic [15:0]            Matrix_Col;
   logic [19:0]            OutMatrix_Row;
   logic [4:0]             Shift;
   logic                   p_valid;
   logic                   p_ready;
   logic [P_W-1:0]         p_data;
   logic                   s_valid;
   logic                   s_ready;
   logic [LANES*ACC_W-1:0] s_data;
   logic                   m_valid;
   logic                   m_ready;
   logic [OUT_W-1:0]       m_data;
   logic                   m_last;
   logic                   done;
   logic                   cfg_err;

   always #5 clk = ~clk;

   quant_pack_stream dut (
      .clk(clk), .rst(rst), .start(start), .Matrix_Col(Matrix_Col),
      .OutMatrix_Row(OutMatrix_Row), .Shift(Shift),
      .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .done(done), .cfg_err(cfg_err)
   );

   int errors = 0;
   int checks = 0;

   int                     bias_t  [CH_MAX];
   int                     scale_t [CH_MAX];
   logic [LANES*ACC_W-1:0] src     [$];
   logic [OUT_W-1:0]       exp_q   [$];
   bit                     exp_last_q [$];
   logic [OUT_W-1:0]       got_q   [$];
   bit                     done_seen = 1'b0;
   bit                     chk_done  = 1'b0;
   bit                     prev_hold = 1'b0;
   bit                     prev_rst  = 1'b1;
   logic [OUT_W-1:0]       prev_data = '0;

   function automatic logic [7:0] model(int acc, int bias, int scale, int sh);
      longint s = longint'(acc) + longint'(bias);
      longint p = s * longint'(scale);
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
      p = p >>> sh;
      if (p > 127) return 8'h7f;
      if (p < -128) return 8'h80;
      return p[7:0];
   endfunction

   // Output monitor: scoreboard pop, hold stability, stall/ready and done pulse.
   always @(negedge clk) begin
      logic [OUT_W-1:0] e;
      bit el;
      if (chk_done) begin
         checks++;
         if (done !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: done=%b required 1", done);
         end
         chk_done  = 1'b0;
         done_seen = 1'b1;
      end
      if (prev_hold && !prev_rst) begin
         checks++;
         if (m_valid !== 1'b1 || m_data !== prev_data) begin
            errors++;
            $display("FAIL hold_stable: m_valid=%b m_data=%h required 1 %h", m_valid, m_data, prev_data);
         end
      end
      if (!rst && m_valid === 1'b1 && m_ready === 1'b0) begin
         checks++;
         if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_sready: s_ready=%b required 0", s_ready);
         end
      end
      if (!rst && m_valid === 1'b1 && m_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: m_data=%h with empty scoreboard", m_data);
         end else begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            got_q.push_back(m_data);
            if (m_data !== e || m_last !== el) begin
               errors++;
               $display("FAIL beat: m_data=%h m_last=%b required %h %b", m_data, m_last, e, el);
            end
            if (m_last === 1'b1) chk_done = 1'b1;
         end
      end
      prev_hold = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data = m_data;
      prev_rst  = rst;
   end

   task automatic do_start(input int col, input int row, input int sh);
      @(posedge clk); #1;
      start = 1'b1;
      Matrix_Col    = 16'(col);
      OutMatrix_Row = 20'(row);
      Shift         = 5'(sh);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_params(input int col);
      int idx = 0;
      int cyc = 0;
      while (idx < col && cyc < 5000) begin
         @(posedge clk); #1;
         p_valid = 1'b1;
         p_data  = {32'(bias_t[idx]), 16'(scale_t[idx])};
         @(negedge clk);
         if (p_ready) idx++;
         cyc++;
      end
      @(posedge clk); #1;
      p_valid = 1'b0;
      checks++;
      if (idx != col) begin
         errors++;
         $display("FAIL param_load: loaded=%0d required %0d", idx, col);
      end
   endtask

   task automatic push_expected(input int col, input int fed, input int nb);
      logic [OUT_W-1:0] e;
      int g = fed % (col / LANES);
      for (int i = 0; i < LANES; i++)
         e[i*8 +: 8] = model(int'($signed(src[fed][i*ACC_W +: ACC_W])),
                             bias_t[g*LANES+i], scale_t[g*LANES+i], int'(Shift));
      exp_q.push_back(e);
      exp_last_q.push_back(fed == nb - 1);
   endtask

   task automatic run_layer(input int col, input int row, input int sh, input bit bp);
      int nb  = (col / LANES) * row;
      int fed = 0;
      int cyc = 0;
      exp_q.delete();
      exp_last_q.delete();
      got_q.delete();
      done_seen = 1'b0;
      do_start(col, row, sh);
      load_params(col);
      while ((fed < nb || !done_seen) && cyc < 5000) begin
         @(posedge clk); #1;
         m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         cyc++;
         s_valid = (fed < nb);
         if (fed < nb) s_data = src[fed];
         @(negedge clk);
         if (s_valid && s_ready) begin
            push_expected(col, fed, nb);
            fed++;
         end
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      m_ready = 1'b1;
      checks++;
      if (!done_seen || exp_q.size() != 0 || fed != nb) begin
         errors++;
         $display("FAIL layer_complete: done_seen=%b pending=%0d fed=%0d required 1 0 %0d",
                  done_seen, exp_q.size(), fed, nb);
      end
   endtask

   task automatic set_identity();
      for (int c = 0; c < CH_MAX; c++) begin
         bias_t[c]  = 0;
         scale_t[c] = 1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({p_ready, s_ready, m_valid, m_last, done, cfg_err} !== 6'b0 || m_data !== '0) begin
         errors++;
         $display("FAIL reset_outputs: ctl=%b m_data=%h required 0 0",
                  {p_ready, s_ready, m_valid, m_last, done, cfg_err}, m_data);
      end
      #1 rst = 1'b0;
   endtask

   task automatic test_identity();
      int vals [LANES] = '{-3, 0, 5, 127, 128, -128, -129, 1};
      logic [LANES*ACC_W-1:0] b;
      logic [OUT_W-1:0] want = 64'h01_80_80_7f_7f_05_00_fd;
      set_identity();
      for (int i = 0; i < LANES; i++) b[i*ACC_W +: ACC_W] = 32'(vals[i]);
      src.delete();
      src.push_back(b);
      src.push_back(b);
      run_layer(8, 2, 0, 1'b0);
      checks++;
      if (got_q.size() != 2 || got_q[0] !== want || got_q[1] !== want) begin
         errors++;
         $display("FAIL identity_bytes: n=%0d beat0=%h required 2 %h", got_q.size(), got_q[0], want);
      end
   endtask

   task automatic test_bias_round();
      logic [LANES*ACC_W-1:0] b = '0;
      set_identity();
      bias_t[0]  = 10;
      scale_t[0] = 3;
      src.delete();
      b[31:0] = 32'(5);
      src.push_back(b);
      b[31:0] = 32'(-7);
      src.push_back(b);
      run_layer(8, 2, 2, 1'b0);
      checks++;
      if (got_q.size() != 2 || got_q[0][7:0] !== 8'h0b || got_q[1][7:0] !== 8'h02) begin
         errors++;
         $display("FAIL bias_round: n=%0d ch0=%h,%h required 2 0b,02", got_q.size(), got_q[0][7:0], got_q[1][7:0]);
      end
   endtask

   task automatic test_channel_map();
      for (int c = 0; c < CH_MAX; c++) begin
         bias_t[c]  = c;
         scale_t[c] = 1;
      end
      src.delete();
      for (int k = 0; k < 6; k++) src.push_back('0);
      run_layer(16, 3, 0, 1'b0);
      checks++;
      if (got_q.size() != 6 || got_q[0] !== 64'h0706050403020100 || got_q[5] !== 64'h0f0e0d0c0b0a0908) begin
         errors++;
         $display("FAIL channel_map: n=%0d beat0=%h beat5=%h required 6 0706050403020100 0f0e0d0c0b0a0908",
                  got_q.size(), got_q[0], got_q[5]);
      end
   endtask

   task automatic test_config_err();
      int bad_col [3] = '{12, 1032, 8};
      int bad_row [3] = '{2, 1, 0};
      for (int k = 0; k < 3; k++) begin
         do_start(bad_col[k], bad_row[k], 0);
         @(negedge clk);
         checks++;
         if (cfg_err !== 1'b1 || p_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse[%0d]: cfg_err=%b p_ready=%b required 1 0", k, cfg_err, p_ready);
         end
         @(negedge clk);
         @(negedge clk);
         checks++;
         if (cfg_err !== 1'b0 || p_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_idle[%0d]: cfg_err=%b p_ready=%b required 0 0", k, cfg_err, p_ready);
         end
      end
      set_identity();
      src.delete();
      src.push_back({8{32'(-200)}});
      run_layer(8, 1, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      for (int c = 0; c < 32; c++) begin
         bias_t[c]  = int'($urandom_range(0, 2000)) - 1000;
         scale_t[c] = int'($urandom_range(0, 300));
      end
      src.delete();
      for (int k = 0; k < 64; k++) begin
         logic [LANES*ACC_W-1:0] b;
         for (int i = 0; i < LANES; i++) begin
            int a = int'($urandom);
            a = a >>> $urandom_range(8, 31);
            b[i*ACC_W +: ACC_W] = 32'(a);
         end
         src.push_back(b);
      end
      run_layer(32, 16, 6, 1'b1);
      checks++;
      if (got_q.size() != 64) begin
         errors++;
         $display("FAIL bp_count: beats=%0d required 64", got_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int fed = 0;
      int cyc = 0;
      set_identity();
      for (int c = 0; c < 8; c++) bias_t[c] = 3 * c - 7;
      src.delete();
      for (int k = 0; k < 16; k++) src.push_back({8{32'(k * 11 - 60)}});
      exp_q.delete();
      exp_last_q.delete();
      do_start(8, 16, 1);
      load_params(8);
      while (fed < 5 && cyc < 100) begin
         @(posedge clk); #1;
         m_ready = 1'b1;
         s_valid = 1'b1;
         s_data  = src[fed];
         @(negedge clk);
         if (s_ready) begin
            push_expected(8, fed, 16);
            fed++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      rst     = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({p_ready, s_ready, m_valid, m_last, done, cfg_err} !== 6'b0 || m_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: ctl=%b m_data=%h required 0 0",
                  {p_ready, s_ready, m_valid, m_last, done, cfg_err}, m_data);
      end
      run_layer(8, 16, 1, 1'b0);
      checks++;
      if (got_q.size() != 16) begin
         errors++;
         $display("FAIL reset_mid_rerun: beats=%0d required 16", got_q.size());
      end
   endtask

   initial begin
      rst           = 1'b1;
      start         = 1'b0;
      Matrix_Col    = '0;
      OutMatrix_Row = '0;
      Shift         = '0;
      p_valid       = 1'b0;
      p_data        = '0;
      s_valid       = 1'b0;
      s_data        = '0;
      m_ready       = 1'b1;
      test_reset();
      test_identity();
      test_bias_round();
      test_channel_map();
      test_config_err();
      test_backpressure();
      test_reset_mid();
      repeat (4) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
